// File: rtl/routing_cfg_loader.sv
// routing_cfg_loader: hunts a serial stream for a sync word, loads a routing BitFile plus
// checksum byte, and commits the BitFile only when the checksum verifies.
`default_nettype none

module routing_cfg_loader #(
  parameter logic [7:0]           SYNC_WORD   = 8'hA5,
  parameter int                   CFG_WIDTH   = 8,
  parameter logic [CFG_WIDTH-1:0] DEFAULT_CFG = 8'hE4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 cfg_data_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_abort_i,
  output logic [CFG_WIDTH-1:0] bit_file_o,
  output logic                 cfg_busy_o,
  output logic                 cfg_done_o,
  output logic                 cfg_err_o
);

  localparam int CNT_W = (CFG_WIDTH > 8) ? $clog2(CFG_WIDTH) : 3;
  localparam logic [CNT_W-1:0] LAST_PAY  = CNT_W'(CFG_WIDTH - 1);
  localparam logic [CNT_W-1:0] LAST_CSUM = CNT_W'(7);
  localparam logic [3:0]       HUNT_SAT  = 4'd8;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    LOAD   = 2'd1,
    CHECK  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [7:0]           win_q, win_d;
  logic [3:0]           hunt_q, hunt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CFG_WIDTH-1:0] pay_q, pay_d;
  logic [7:0]           csum_q, csum_d;
  logic [CFG_WIDTH-1:0] bf_q, bf_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 busy_q, busy_d;
  logic                 ready_q, ready_d;

  logic                 accept;
  logic [7:0]           win_shift;
  logic [3:0]           hunt_inc;
  logic [7:0]           sum;

  assign accept    = cfg_valid_i && ready_q;
  assign win_shift = {win_q[6:0], cfg_data_i};
  assign hunt_inc  = (hunt_q == HUNT_SAT) ? HUNT_SAT : hunt_q + 4'd1;
  // Checksum is defined over the low byte of the payload.
  assign sum       = pay_q[7:0] + csum_q;

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    hunt_d  = hunt_q;
    cnt_d   = cnt_q;
    pay_d   = pay_q;
    csum_d  = csum_q;
    bf_d    = bf_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    if (cfg_abort_i) begin
      state_d = HUNT;
      win_d   = '0;
      hunt_d  = '0;
      cnt_d   = '0;
      pay_d   = '0;
      csum_d  = '0;
    end else begin
      case (state_q)
        HUNT: begin
          if (accept) begin
            win_d  = win_shift;
            hunt_d = hunt_inc;
            if (win_shift == SYNC_WORD && hunt_inc == HUNT_SAT) begin
              state_d = LOAD;
              cnt_d   = '0;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            pay_d = {pay_q[CFG_WIDTH-2:0], cfg_data_i};
            if (cnt_q == LAST_PAY) begin
              state_d = CHECK;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        CHECK: begin
          if (accept) begin
            csum_d = {csum_q[6:0], cfg_data_i};
            if (cnt_q == LAST_CSUM) begin
              state_d = COMMIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        COMMIT: begin
          if (sum == 8'd0) begin
            bf_d   = pay_q;
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          // Sync bits are never shared across frames.
          state_d = HUNT;
          win_d   = '0;
          hunt_d  = '0;
          cnt_d   = '0;
        end
        default: state_d = HUNT;
      endcase
    end

    ready_d = (state_d != COMMIT);
    busy_d  = (state_d != HUNT);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= HUNT;
      win_q   <= '0;
      hunt_q  <= '0;
      cnt_q   <= '0;
      pay_q   <= '0;
      csum_q  <= '0;
      bf_q    <= DEFAULT_CFG;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      hunt_q  <= hunt_d;
      cnt_q   <= cnt_d;
      pay_q   <= pay_d;
      csum_q  <= csum_d;
      bf_q    <= bf_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign cfg_ready_o = ready_q;
  assign bit_file_o  = bf_q;
  assign cfg_busy_o  = busy_q;
  assign cfg_done_o  = done_q;
  assign cfg_err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_routing_cfg_loader.sv
// Scoreboard bench for routing_cfg_loader: frames push expected commit/error results,
// a negedge monitor pops them when the DUT pulses done/err.
`default_nettype none

module tb_routing_cfg_loader;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       cfg_data_i = 1'b0;
  logic       cfg_valid_i = 1'b0;
  logic       cfg_abort_i = 1'b0;
  logic       cfg_ready_o;
  logic [7:0] bit_file_o;
  logic       cfg_busy_o;
  logic       cfg_done_o;
  logic       cfg_err_o;

  routing_cfg_loader #(
    .SYNC_WORD  (8'hA5),
    .CFG_WIDTH  (8),
    .DEFAULT_CFG(8'hE4)
  ) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cfg_data_i (cfg_data_i),
    .cfg_valid_i(cfg_valid_i),
    .cfg_ready_o(cfg_ready_o),
    .cfg_abort_i(cfg_abort_i),
    .bit_file_o (bit_file_o),
    .cfg_busy_o (cfg_busy_o),
    .cfg_done_o (cfg_done_o),
    .cfg_err_o  (cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       pass;
    logic [7:0] bf;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] model_bf = 8'hE4;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;

  // Scoreboard monitor: every pulse must match the oldest outstanding frame.
  always @(negedge clk_i) begin : mon
    exp_t e;
    if (rst_ni && (cfg_done_o || cfg_err_o)) begin
      if (cfg_done_o) done_cnt++;
      if (cfg_err_o) err_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse done=%b err=%b bit_file=%h required no pulse",
                 cfg_done_o, cfg_err_o, bit_file_o);
      end else begin
        e = exp_q.pop_front();
        if (cfg_done_o !== e.pass || cfg_err_o !== !e.pass || bit_file_o !== e.bf) begin
          errors++;
          $display("FAIL scoreboard done=%b err=%b bit_file=%h required done=%b err=%b bit_file=%h",
                   cfg_done_o, cfg_err_o, bit_file_o, e.pass, !e.pass, e.bf);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic b);
    int guard = 0;
    @(negedge clk_i);
    while (!cfg_ready_o && guard < 16) begin
      @(negedge clk_i);
      guard++;
    end
    cfg_valid_i = 1'b1;
    cfg_data_i  = b;
    @(posedge clk_i);
    #1;
    cfg_valid_i = 1'b0;
    cfg_data_i  = 1'($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic push_exp(input logic [7:0] pay, input logic [7:0] cs);
    exp_t       e;
    logic [7:0] s;
    s      = pay + cs;
    e.pass = (s == 8'd0);
    if (e.pass) model_bf = pay;
    e.bf   = model_bf;
    exp_q.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] pay, input logic [7:0] cs);
    push_exp(pay, cs);
    send_byte(8'hA5);
    send_byte(pay);
    send_byte(cs);
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 20) begin
      @(negedge clk_i);
      g++;
    end
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if (bit_file_o !== 8'hE4 || cfg_done_o !== 1'b0 || cfg_err_o !== 1'b0 ||
        cfg_busy_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state bf=%h done=%b err=%b busy=%b ready=%b required E4 0 0 0 0",
               bit_file_o, cfg_done_o, cfg_err_o, cfg_busy_o, cfg_ready_o);
    end
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    checks++;
    if (cfg_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset ready=%b required 1", cfg_ready_o);
    end
    // Seven bits since reset cannot lock.
    for (int i = 6; i >= 0; i--) send_bit(i[0] ^ 1'b1 ? 1'b0 : 1'b1);
    repeat (2) @(negedge clk_i);
    checks++;
    if (cfg_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL seven_bit_no_lock busy=%b required 0", cfg_busy_o);
    end
  endtask

  task automatic test_bad_checksum();
    int e0 = err_cnt;
    int d0 = done_cnt;
    send_frame(8'h1B, 8'h00);
    @(posedge clk_i);
    #1;
    checks++;
    if (cfg_err_o !== 1'b1 || cfg_done_o !== 1'b0 || bit_file_o !== 8'hE4) begin
      errors++;
      $display("FAIL bad_cs_edge err=%b done=%b bf=%h required 1 0 E4",
               cfg_err_o, cfg_done_o, bit_file_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (cfg_err_o !== 1'b0 || cfg_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL bad_cs_fall err=%b busy=%b required 0 0", cfg_err_o, cfg_busy_o);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || err_cnt != e0 + 1 || done_cnt != d0) begin
      errors++;
      $display("FAIL bad_cs_count pending=%0d errs=%0d dones=%0d required 0 %0d %0d",
               exp_q.size(), err_cnt - e0, done_cnt - d0, 1, 0);
    end
  endtask

  task automatic test_basic_frame();
    int d0 = done_cnt;
    send_frame(8'h1B, 8'hE5);
    checks++;
    if (cfg_done_o !== 1'b0 || bit_file_o !== 8'hE4 || cfg_ready_o !== 1'b0 || cfg_busy_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_commit done=%b bf=%h ready=%b busy=%b required 0 E4 0 1",
               cfg_done_o, bit_file_o, cfg_ready_o, cfg_busy_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (cfg_done_o !== 1'b1 || bit_file_o !== 8'h1B) begin
      errors++;
      $display("FAIL commit_edge done=%b bf=%h required 1 1B", cfg_done_o, bit_file_o);
    end
    @(posedge clk_i);
    #1;
    checks++;
    if (cfg_done_o !== 1'b0) begin
      errors++;
      $display("FAIL done_fall done=%b required 0", cfg_done_o);
    end
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL basic_count pending=%0d dones=%0d required 0 1", exp_q.size(), done_cnt - d0);
    end
  endtask

  task automatic test_noise();
    int d0 = done_cnt;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_frame(8'h39, 8'hC7);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || bit_file_o !== 8'h39 || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL noise pending=%0d bf=%h dones=%0d required 0 39 1",
               exp_q.size(), bit_file_o, done_cnt - d0);
    end
  endtask

  task automatic test_stalls();
    push_exp(8'h1B, 8'hE5);
    send_byte(8'hA5);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_busy_o !== 1'b1 || bit_file_o !== 8'h39) begin
        errors++;
        $display("FAIL load_stall busy=%b bf=%h required 1 39", cfg_busy_o, bit_file_o);
      end
    end
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      checks++;
      if (cfg_busy_o !== 1'b1 || bit_file_o !== 8'h39) begin
        errors++;
        $display("FAIL check_stall busy=%b bf=%h required 1 39", cfg_busy_o, bit_file_o);
      end
    end
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || bit_file_o !== 8'h1B) begin
      errors++;
      $display("FAIL stall_result pending=%0d bf=%h required 0 1B", exp_q.size(), bit_file_o);
    end
  endtask

  task automatic test_abort();
    int d0 = done_cnt;
    int e0 = err_cnt;
    send_byte(8'hA5);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    @(negedge clk_i);
    cfg_abort_i = 1'b1;
    cfg_valid_i = 1'b1;
    cfg_data_i  = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_abort_i = 1'b0;
    cfg_valid_i = 1'b0;
    checks++;
    if (cfg_busy_o !== 1'b0 || bit_file_o !== 8'h1B) begin
      errors++;
      $display("FAIL abort_load busy=%b bf=%h required 0 1B", cfg_busy_o, bit_file_o);
    end
    send_frame(8'h6C, 8'h94);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || bit_file_o !== 8'h6C || done_cnt != d0 + 1) begin
      errors++;
      $display("FAIL abort_reload pending=%0d bf=%h dones=%0d required 0 6C 1",
               exp_q.size(), bit_file_o, done_cnt - d0);
    end
    // Good frame, aborted in its COMMIT cycle: nothing pushed, nothing expected.
    send_byte(8'hA5);
    send_byte(8'h1B);
    send_byte(8'hE5);
    cfg_abort_i = 1'b1;
    @(posedge clk_i);
    #1;
    cfg_abort_i = 1'b0;
    checks++;
    if (cfg_done_o !== 1'b0 || cfg_err_o !== 1'b0 || bit_file_o !== 8'h6C || cfg_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_commit done=%b err=%b bf=%h busy=%b required 0 0 6C 0",
               cfg_done_o, cfg_err_o, bit_file_o, cfg_busy_o);
    end
    repeat (3) @(negedge clk_i);
    checks++;
    if (done_cnt != d0 + 1 || err_cnt != e0) begin
      errors++;
      $display("FAIL abort_commit_count dones=%0d errs=%0d required 1 0", done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_reset_midframe();
    send_frame(8'h1B, 8'hE5);
    wait_drain();
    send_byte(8'hA5);
    send_byte(8'h1B);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if (bit_file_o !== 8'hE4 || cfg_done_o !== 1'b0 || cfg_err_o !== 1'b0 ||
        cfg_busy_o !== 1'b0 || cfg_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset bf=%h done=%b err=%b busy=%b ready=%b required E4 0 0 0 0",
               bit_file_o, cfg_done_o, cfg_err_o, cfg_busy_o, cfg_ready_o);
    end
    @(negedge clk_i);
    rst_ni   = 1'b1;
    model_bf = 8'hE4;
    send_frame(8'h1B, 8'hE5);
    wait_drain();
    checks++;
    if (exp_q.size() != 0 || bit_file_o !== 8'h1B) begin
      errors++;
      $display("FAIL post_reset_frame pending=%0d bf=%h required 0 1B", exp_q.size(), bit_file_o);
    end
  endtask

  initial begin
    test_reset();
    test_bad_checksum();
    test_basic_frame();
    test_noise();
    test_stalls();
    test_abort();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/routing_cfg_loader.md
Name: routing_cfg_loader

Overview:
- Serial configuration loader directly upstream of the routing channel.
- Hunts a serial bitstream for a sync word, then shifts in the 8-bit routing BitFile and a checksum byte.
- Commits the BitFile to a registered output only after the checksum verifies, so the routing channel never sees a partial or corrupt configuration.
- Holds an identity routing default (each CLB takes its own slice and carry chain) from reset until the first good frame.

Parameters:
- SYNC_WORD, 8'hA5, frame start pattern, MSB first.
- CFG_WIDTH, 8, payload width; equals the routing BitFile width.
- DEFAULT_CFG, 8'hE4, BitFile value after reset: fields [1:0]=00, [3:2]=01, [5:4]=10, [7:6]=11.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cfg_data  in  1  serial config bit.
- cfg_valid  in  1  cfg_data is valid this cycle.
- cfg_ready  out  1  loader can accept a bit this cycle.
- cfg_abort  in  1  drop any frame in progress and return to HUNT.
- bit_file  out  CFG_WIDTH  active routing configuration; feeds the routing channel BitFile.
- cfg_busy  out  1  high in LOAD, CHECK and COMMIT.
- cfg_done  out  1  one-cycle pulse on successful commit.
- cfg_err  out  1  one-cycle pulse on checksum failure.

Behaviour:
- A bit is accepted on a rising edge when cfg_valid && cfg_ready. cfg_data is ignored otherwise. Bit order is MSB first throughout.
- Reset (rst_n low at an edge), outputs and state:
  - bit_file=DEFAULT_CFG, cfg_done=0, cfg_err=0, cfg_busy=0, cfg_ready=0.
  - state=HUNT, sync window=0, hunt count=0, bit counter=0, payload shadow=0.
  - cfg_ready rises on the first cycle after rst_n is high.
  - Reset mid-frame discards the frame and restores DEFAULT_CFG.
- cfg_ready is registered: 0 in COMMIT and during reset, 1 otherwise.
- HUNT:
  - Each accepted bit shifts into the 8-bit window. The hunt count increments, saturating at 8.
  - Go to LOAD on the edge where the post-shift window == SYNC_WORD and the post-increment count == 8.
  - No match found stays in HUNT indefinitely.
- LOAD:
  - Shift CFG_WIDTH accepted bits into the payload shadow. The bit counter counts 0..CFG_WIDTH-1.
  - Go to CHECK on the edge accepting the last payload bit.
  - Stalls (cfg_valid low) of any length leave state and counters unchanged.
- CHECK:
  - Shift 8 accepted bits into the checksum register.
  - Go to COMMIT on the edge accepting the 8th bit.
- Checksum rule: (payload + checksum) mod 256 == 0, computed over the 8-bit payload.
- COMMIT (exactly one cycle); at its exit edge:
  - Pass: bit_file <= payload shadow, cfg_done <= 1.
  - Fail: bit_file unchanged, cfg_err <= 1.
  - Either way: next state HUNT, window and hunt count cleared. Sync bits are never shared across frames.
- Latency: last checksum bit accepted at edge E0. Then bit_file and cfg_done/cfg_err change at E1, and the pulse falls at E2.
- cfg_busy is registered: 1 in LOAD, CHECK and COMMIT, 0 in HUNT.
- cfg_abort:
  - In any state, abort at an edge forces HUNT and clears window, hunt count, bit counter, payload shadow and checksum register. bit_file is unchanged.
  - Abort wins over a simultaneous valid bit; that bit is discarded.
  - Abort in COMMIT cancels the commit: no cfg_done and no cfg_err.
  - Abort in HUNT clears the window.
- bit_file changes only at a passing COMMIT exit or at reset. It never changes during LOAD or CHECK.

Test Plan:
- Reset, then frame A5, 1B, E5 with continuous valid -> bit_file E4 until the commit edge, then 1B. cfg_done high exactly 1 cycle, 25 edges after the first sync bit is accepted.
- Frame A5, 1B, 00 -> cfg_err pulses for 1 cycle, cfg_done stays 0, bit_file stays E4, state returns to HUNT (cfg_busy 0).
- Frame A5, 1B, E5 with cfg_valid low for 5 cycles after payload bit 3 and for 2 cycles inside the checksum -> bit_file 1B. cfg_busy stays high throughout the stalls.
- Noise bits 1,1,0,0 then A5, 39, C7 -> bit_file 39, exactly one cfg_done. Also a bare A5 with only 7 bits received since reset -> no lock.
- cfg_abort after payload bit 4 of A5, 1B, ..., then full frame A5, 6C, 94 -> bit_file 6C, a single cfg_done. Repeat with abort coinciding with the COMMIT cycle -> no pulses, bit_file unchanged.
- rst_n low for 1 cycle mid-checksum after a prior commit of 1B -> bit_file E4 and all flags 0 on the reset edge. The next full frame A5, 1B, E5 loads correctly.
